// File: rtl/forth_instr_encoder.sv
// Forth instruction encoder: packs operation records into 16-bit words
// and streams them to instruction memory at an auto-incrementing address.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   start, start_addr   begin a stream (IDLE only) at start_addr
//   clr                 DONE/ERROR -> IDLE
//   in_valid/in_ready   record handshake
//   in_kind..in_last    record fields
//   im_we/addr/wdata    instruction-memory write port (registered)
//   busy, done, err     state flags; err_code gives error cause
//   count               words written in current stream
module forth_instr_encoder #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [15:0]       in_arg,
  input  logic [3:0]        in_aluop,
  input  logic [1:0]        in_src,
  input  logic [1:0]        in_dst,
  input  logic [1:0]        in_doff,
  input  logic [1:0]        in_roff,
  input  logic              in_swap,
  input  logic              in_last,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [15:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [1:0] E_KIND = 2'd0;
  localparam logic [1:0] E_IMM  = 2'd1;
  localparam logic [1:0] E_TGT  = 2'd2;
  localparam logic [1:0] E_ADDR = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;

  logic [15:0] w_word;
  logic        w_bad;
  logic [1:0]  w_code;
  logic        w_tgt_ovf;
  logic        w_acc;
  logic        w_addr_max;

  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign err      = (r_state == S_ERR);
  assign in_ready = busy;

  assign w_acc      = in_valid & in_ready;
  assign w_addr_max = &r_addr;

  // Target must fit in 13 bits and in the address space when it is narrower.
  assign w_tgt_ovf = (in_arg[15:13] != 3'b000) ||
                     ((32'(in_arg) >> ADDR_W) != 32'd0);

  always_comb begin
    w_word = 16'h0000;
    w_bad  = 1'b0;
    w_code = E_KIND;
    unique case (in_kind)
      3'd0: begin
        w_word = {1'b1, in_arg[14:0]};
        if (in_arg[15]) begin
          w_bad  = 1'b1;
          w_code = E_IMM;
        end
      end
      3'd1: w_word = 16'h0000;
      3'd2, 3'd3, 3'd4: begin
        w_word = {in_kind - 3'd1, in_arg[12:0]};
        if (w_tgt_ovf) begin
          w_bad  = 1'b1;
          w_code = E_TGT;
        end
      end
      3'd5: begin
        w_word = {3'b000, in_aluop, in_src, in_dst,
                  in_doff, in_roff, in_swap};
        if (in_aluop == 4'd0) begin
          w_bad  = 1'b1;
          w_code = E_KIND;
        end
      end
      default: begin
        w_bad  = 1'b1;
        w_code = E_KIND;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= 16'h0000;
      err_code <= 2'd0;
      count    <= '0;
    end else begin
      im_we <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_RUN;
            r_addr   <= start_addr;
            count    <= '0;
            err_code <= 2'd0;
            im_addr  <= '0;
            im_wdata <= 16'h0000;
          end
        end
        S_RUN: begin
          if (w_acc) begin
            if (w_bad) begin
              r_state  <= S_ERR;
              err_code <= w_code;
            end else begin
              im_we    <= 1'b1;
              im_addr  <= r_addr;
              im_wdata <= w_word;
              count    <= count + {{ADDR_W{1'b0}}, 1'b1};
              if (in_last) begin
                r_state <= S_DONE;
              end else if (w_addr_max) begin
                // Last address used; the counter must not wrap.
                r_state  <= S_ERR;
                err_code <= E_ADDR;
              end else begin
                r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
              end
            end
          end
        end
        S_DONE, S_ERR: begin
          if (clr) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_forth_instr_encoder.sv
// Directed testbench for forth_instr_encoder.
module tb_forth_instr_encoder;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_kind;
  logic [15:0]   in_arg;
  logic [3:0]    in_aluop;
  logic [1:0]    in_src;
  logic [1:0]    in_dst;
  logic [1:0]    in_doff;
  logic [1:0]    in_roff;
  logic          in_swap;
  logic          in_last;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [15:0]   im_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [AW:0]   count;

  int nvec = 0;
  int nmis = 0;

  forth_instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_arg(in_arg), .in_aluop(in_aluop),
    .in_src(in_src), .in_dst(in_dst), .in_doff(in_doff),
    .in_roff(in_roff), .in_swap(in_swap), .in_last(in_last),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .count(count)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs were set before, outputs sampled 1 after.
  task automatic step();
    @(posedge clk);
    #1;
    start = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_kind = 3'd0; in_arg = 16'h0;
    in_aluop = 4'd0; in_src = 2'd0; in_dst = 2'd0;
    in_doff = 2'd0; in_roff = 2'd0; in_swap = 1'b0; in_last = 1'b0;
  endtask

  task automatic rec(input logic [2:0] k, input logic [15:0] a,
                     input logic l);
    in_valid = 1'b1; in_kind = k; in_arg = a; in_last = l;
  endtask

  task automatic begin_stream(input logic [AW-1:0] a);
    idle_in();
    start = 1'b1;
    start_addr = a;
    step();
  endtask

  // Expected write port as one vector: {we, addr, data}
  task automatic chk_wr(input string nm, input logic we,
                        input logic [AW-1:0] a, input logic [15:0] d);
    nvec++;
    if ({im_we, im_addr, im_wdata} !== {we, a, d}) begin
      nmis++;
      $display("FAIL %s: got we=%0b addr=%h data=%h, want we=%0b addr=%h data=%h",
               nm, im_we, im_addr, im_wdata, we, a, d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; clr = 1'b0; start_addr = '0;
    idle_in();
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if ({im_we, im_addr, im_wdata, busy, done, err, err_code, count,
         in_ready} !== '0) begin
      nmis++;
      $display("FAIL reset: outputs not zero we=%0b addr=%h data=%h busy=%0b done=%0b err=%0b code=%0d cnt=%0d rdy=%0b",
               im_we, im_addr, im_wdata, busy, done, err, err_code,
               count, in_ready);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_stream();
    begin_stream(13'h010);
    nvec++;
    if ({busy, in_ready, count} !== {1'b1, 1'b1, 14'd0}) begin
      nmis++;
      $display("FAIL run_entry: busy=%0b rdy=%0b cnt=%0d want 1 1 0",
               busy, in_ready, count);
    end
    rec(3'd0, 16'h1234, 1'b0); step();
    chk_wr("imm", 1'b1, 13'h010, 16'h9234);
    rec(3'd2, 16'h0ABC, 1'b0); step();
    chk_wr("j", 1'b1, 13'h011, 16'h2ABC);
    rec(3'd4, 16'h0005, 1'b0); step();
    chk_wr("jz", 1'b1, 13'h012, 16'h6005);
    rec(3'd1, 16'h0000, 1'b1); step();
    chk_wr("jr", 1'b1, 13'h013, 16'h0000);
    idle_in();
    nvec++;
    if ({done, busy, in_ready, count} !== {1'b1, 1'b0, 1'b0, 14'd4}) begin
      nmis++;
      $display("FAIL stream_done: done=%0b busy=%0b rdy=%0b cnt=%0d want 1 0 0 4",
               done, busy, in_ready, count);
    end
    start = 1'b1; start_addr = 13'h055; step();
    nvec++;
    if ({done, busy, im_we} !== 3'b100) begin
      nmis++;
      $display("FAIL start_in_done: done=%0b busy=%0b we=%0b want 1 0 0",
               done, busy, im_we);
    end
    clr = 1'b1; step();
    nvec++;
    if ({done, busy, err} !== 3'b000) begin
      nmis++;
      $display("FAIL clr_done: done=%0b busy=%0b err=%0b want 0 0 0",
               done, busy, err);
    end
  endtask

  task automatic test_alu();
    begin_stream(13'h100);
    rec(3'd5, 16'h0, 1'b1);
    in_aluop = 4'd3; in_src = 2'd3; in_dst = 2'd1;
    in_doff = 2'd1; in_roff = 2'd3; in_swap = 1'b1;
    step();
    chk_wr("alu", 1'b1, 13'h100, 16'h07AF);
    idle_in();
    clr = 1'b1; step();
  endtask

  task automatic test_imm_err();
    begin_stream(13'h020);
    rec(3'd0, 16'h0001, 1'b0); step();
    chk_wr("imm_ok", 1'b1, 13'h020, 16'h8001);
    rec(3'd0, 16'h8000, 1'b0); step();
    idle_in();
    chk_wr("imm_ovf_nowrite", 1'b0, 13'h020, 16'h8001);
    nvec++;
    if ({err, err_code, in_ready, count} !== {1'b1, 2'd1, 1'b0, 14'd1}) begin
      nmis++;
      $display("FAIL imm_ovf: err=%0b code=%0d rdy=%0b cnt=%0d want 1 1 0 1",
               err, err_code, in_ready, count);
    end
    clr = 1'b1; step();
    nvec++;
    if ({err, busy} !== 2'b00) begin
      nmis++;
      $display("FAIL clr_err: err=%0b busy=%0b want 0 0", err, busy);
    end
  endtask

  // Error codes for target overflow, bad kind, zero aluop.
  task automatic test_code_errs();
    logic [2:0]  ks [3] = '{3'd3, 3'd6, 3'd5};
    logic [15:0] as [3] = '{16'h2000, 16'h0000, 16'h0000};
    logic [1:0]  cs [3] = '{2'd2, 2'd0, 2'd0};
    for (int i = 0; i < 3; i++) begin
      begin_stream(13'h200);
      rec(ks[i], as[i], 1'b0); step();
      idle_in();
      nvec++;
      if ({im_we, err, err_code} !== {1'b0, 1'b1, cs[i]}) begin
        nmis++;
        $display("FAIL code_err[%0d]: we=%0b err=%0b code=%0d want 0 1 %0d",
                 i, im_we, err, err_code, cs[i]);
      end
      clr = 1'b1; step();
    end
    begin_stream(13'h300);
    rec(3'd3, 16'h1FFF, 1'b1); step();
    chk_wr("jal_max", 1'b1, 13'h300, 16'h5FFF);
    idle_in();
    clr = 1'b1; step();
  endtask

  task automatic test_addr_ovf();
    begin_stream(13'h1FFF);
    rec(3'd0, 16'h0005, 1'b0); step();
    idle_in();
    chk_wr("addr_top", 1'b1, 13'h1FFF, 16'h8005);
    nvec++;
    if ({err, err_code, count} !== {1'b1, 2'd3, 14'd1}) begin
      nmis++;
      $display("FAIL addr_ovf: err=%0b code=%0d cnt=%0d want 1 3 1",
               err, err_code, count);
    end
    step();
    chk_wr("addr_ovf_pulse", 1'b0, 13'h1FFF, 16'h8005);
    clr = 1'b1; step();
  endtask

  task automatic test_back_to_back();
    begin_stream(13'h040);
    rec(3'd0, 16'h0001, 1'b0); step();
    chk_wr("gap_w0", 1'b1, 13'h040, 16'h8001);
    idle_in(); step();
    nvec++;
    if ({im_we, busy} !== 2'b01) begin
      nmis++;
      $display("FAIL gap: we=%0b busy=%0b want 0 1", im_we, busy);
    end
    rec(3'd0, 16'h0002, 1'b1); step();
    chk_wr("gap_w1", 1'b1, 13'h041, 16'h8002);
    idle_in();
    nvec++;
    if ({done, count} !== {1'b1, 14'd2}) begin
      nmis++;
      $display("FAIL gap_done: done=%0b cnt=%0d want 1 2", done, count);
    end
    clr = 1'b1; step();
  endtask

  task automatic test_mid_reset();
    begin_stream(13'h060);
    rec(3'd0, 16'h0007, 1'b0); step();
    chk_wr("pre_rst", 1'b1, 13'h060, 16'h8007);
    #1 rst = 1'b1;
    #1;
    nvec++;
    if ({im_we, busy, count} !== {1'b0, 1'b0, 14'd0}) begin
      nmis++;
      $display("FAIL mid_reset: we=%0b busy=%0b cnt=%0d want 0 0 0",
               im_we, busy, count);
    end
    step();
    idle_in();
    rst = 1'b0;
    step();
    begin_stream(13'h050);
    rec(3'd0, 16'h0003, 1'b1); step();
    chk_wr("post_rst", 1'b1, 13'h050, 16'h8003);
    idle_in();
    nvec++;
    if ({done, count} !== {1'b1, 14'd1}) begin
      nmis++;
      $display("FAIL post_rst_done: done=%0b cnt=%0d want 1 1", done, count);
    end
    clr = 1'b1; step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_alu();
    test_imm_err();
    test_code_errs();
    test_addr_ovf();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
